mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter (CPU MEM stage = port 0, loader/debug = port 1) with lock/burst limit.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin contention; default build is fixed priority to port 0.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  cpu_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] burst_q;
  logic       last_q;

  logic own0, own1, granted, we_sel;
  logic under_lim, keep0, keep1;
  logic [7:0] burst_inc;

  assign own0    = (state_q == OWN0);
  assign own1    = (state_q == OWN1);
  assign gnt0    = own0 & req0;
  assign gnt1    = own1 & req1;
  assign granted = gnt0 | gnt1;
  assign we_sel  = own1 ? we1 : we0;

  assign mem_addr  = own0 ? addr0  : (own1 ? addr1  : '0);
  assign mem_wdata = own0 ? wdata0 : (own1 ? wdata1 : '0);
  assign mem_we    = granted & we_sel;
  assign mem_re    = granted & ~we_sel;
  assign rdata     = mem_re ? mem_rdata : '0;
  assign cpu_stall = req0 & ~gnt0;

  // Without round-robin, port 0 ignores the burst limit and may hold under lock forever.
  assign under_lim = (burst_q < BURST_LIM);
  assign keep0     = req0 & lock0 & (under_lim | ~req1 | ~RR_EN);
  assign keep1     = req1 & lock1 & (under_lim | ~req0);
  assign burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      if (gnt0)      last_q <= 1'b0;
      else if (gnt1) last_q <= 1'b1;

      case (state_q)
        IDLE: begin
          burst_q <= '0;
          if (req0 & req1) state_q <= (RR_EN & ~last_q) ? OWN1 : OWN0;
          else if (req0)   state_q <= OWN0;
          else if (req1)   state_q <= OWN1;
          else             state_q <= IDLE;
        end
        OWN0: begin
          if (keep0 | (req0 & (~req1 | ~RR_EN))) begin
            burst_q <= burst_inc;
          end else if (req1) begin
            state_q <= OWN1;
            burst_q <= '0;
          end else begin
            state_q <= IDLE;
            burst_q <= '0;
          end
        end
        OWN1: begin
          // At a switch point port 0 wins in both modes: round-robin favours the non-last owner.
          if (keep1 | (req1 & ~req0)) begin
            burst_q <= burst_inc;
          end else if (req0) begin
            state_q <= OWN0;
            burst_q <= '0;
          end else begin
            state_q <= IDLE;
            burst_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          burst_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a port-level ownership model and a word memory model.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 8;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic          req_i   [2];
  logic          we_i    [2];
  logic          lock_i  [2];
  logic [AW-1:0] addr_i  [2];
  logic [DW-1:0] wdata_i [2];
  logic gnt0, gnt1, cpu_stall, mem_we, mem_re;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] dmem [16] = '{default: '0};
  assign mem_rdata = dmem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req_i[0]), .req1(req_i[1]), .we0(we_i[0]), .we1(we_i[1]),
    .lock0(lock_i[0]), .lock1(lock_i[1]), .addr0(addr_i[0]), .addr1(addr_i[1]),
    .wdata0(wdata_i[0]), .wdata1(wdata_i[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  int n_pass = 0;
  int n_total = 0;

  // Model: current owner (-1 = nobody), consecutive-grant run, last granted port, memory image.
  int owner, run, last;
  int wait_c [2];
  bit pend [2];
  logic [DW-1:0] mmem [16] = '{default: '0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    owner = -1; run = 0; last = 1;
    for (int p = 0; p < 2; p++) begin wait_c[p] = 0; pend[p] = 1'b0; end
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      req_i[p] = 1'b0; we_i[p] = 1'b0; lock_i[p] = 1'b0; addr_i[p] = '0; wdata_i[p] = '0;
    end
  endtask

  task automatic compare_model();
    bit eg [2];
    bit dut_g;
    logic ewe, ere;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, er;
    eg[0] = (owner == 0) && req_i[0];
    eg[1] = (owner == 1) && req_i[1];
    ewe = 1'b0; ere = 1'b0; ea = '0; ed = '0; er = '0;
    if (owner >= 0) begin
      ea  = addr_i[owner];
      ed  = wdata_i[owner];
      ewe = eg[owner] && we_i[owner];
      ere = eg[owner] && !we_i[owner];
      if (ere) er = mmem[ea[5:2]];
    end
    chk("gnt0", 64'(gnt0), 64'(eg[0]));
    chk("gnt1", 64'(gnt1), 64'(eg[1]));
    chk("mem_we", 64'(mem_we), 64'(ewe));
    chk("mem_re", 64'(mem_re), 64'(ere));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("mem_wdata", 64'(mem_wdata), 64'(ed));
    chk("rdata", 64'(rdata), 64'(er));
    chk("cpu_stall", 64'(cpu_stall), 64'(req_i[0] && !eg[0]));
    chk("excl", 64'(gnt0 & gnt1), 64'(0));
    for (int p = 0; p < 2; p++) begin
      dut_g = (p == 1) ? gnt1 : gnt0;
      if (dut_g) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        chk("fair_wait_bound", 64'(wait_c[p] <= MB + 1), 64'(1));
`endif
        wait_c[p] = 0;
      end else if (req_i[p]) wait_c[p]++;
      else wait_c[p] = 0;
      pend[p] = req_i[p] && !eg[p];
    end
  endtask

  // Ownership rules applied at the clock edge to this cycle's inputs.
  task automatic model_step();
    int x, y, w;
    bit granted, both, keep;
    granted = (owner >= 0) && req_i[owner];
    if (granted && we_i[owner]) mmem[addr_i[owner][5:2]] = wdata_i[owner];
    both = req_i[0] && req_i[1];
    if (owner < 0) begin
      run = 0;
      if (both) owner = RR ? 1 - last : 0;
      else if (req_i[0]) owner = 0;
      else if (req_i[1]) owner = 1;
    end else begin
      x = owner; y = 1 - x;
      if (granted) last = x;
      keep = req_i[x] && lock_i[x] && (run < MB - 1 || !req_i[y] || (!RR && x == 0));
      w = x;
      if (!keep && both) w = RR ? 1 - last : 0;
      else if (!keep && req_i[y]) w = y;
      else if (!keep && !req_i[x]) w = -1;
      if (w == x) run = (run < 255) ? run + 1 : 255;
      else begin owner = w; run = 0; end
    end
  endtask

  task automatic eval_cycle();
    #3;
    compare_model();
  endtask

  task automatic next_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    bit e0, e1;
    clear_inputs();
    reset = 1'b1;
    req_i[0] = 1'b1; we_i[0] = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    chk("rst_gnt0", 64'(gnt0), 64'(0));
    chk("rst_gnt1", 64'(gnt1), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_re", 64'(mem_re), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_cpu_stall", 64'(cpu_stall), 64'(1));

    // Single write from port 0 after reset.
    do_reset();
    req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 32'h10; wdata_i[0] = 32'hCAFE;
    eval_cycle();
    chk("wr_c0_gnt0", 64'(gnt0), 64'(0));
    chk("wr_c0_stall", 64'(cpu_stall), 64'(1));
    next_cycle();
    eval_cycle();
    chk("wr_c1_gnt0", 64'(gnt0), 64'(1));
    chk("wr_c1_mem_we", 64'(mem_we), 64'(1));
    chk("wr_c1_addr", 64'(mem_addr), 64'(32'h10));
    next_cycle();
    chk("wr_commit", 64'(dmem[4]), 64'(32'hCAFE));
    req_i[0] = 1'b0; we_i[0] = 1'b0;
    eval_cycle();
    next_cycle();

    // Continuous contention without lock: alternation (round-robin) or port 0 only (fixed).
    do_reset();
    req_i[0] = 1'b1; addr_i[0] = 32'h10;
    req_i[1] = 1'b1; addr_i[1] = 32'h4;
    for (int i = 0; i < 9; i++) begin
      eval_cycle();
      if (RR) begin e0 = (i % 2 == 1); e1 = (i >= 1) && (i % 2 == 0); end
      else begin e0 = (i >= 1); e1 = 1'b0; end
      chk("cont_gnt0", 64'(gnt0), 64'(e0));
      chk("cont_gnt1", 64'(gnt1), 64'(e1));
      if (e0) chk("cont_rdata", 64'(rdata), 64'(32'hCAFE));
      if (e1) chk("cont_stall", 64'(cpu_stall), 64'(1));
      next_cycle();
    end
    req_i[0] = 1'b0;
    eval_cycle();
    chk("drop_gnt0", 64'(gnt0), 64'(0));
    chk("drop_gnt1", 64'(gnt1), 64'(0));
    next_cycle();
    eval_cycle();
    chk("drop_next_gnt1", 64'(gnt1), 64'(1));
    next_cycle();

    // Locked port 1 burst: 8 grants, then port 0.
    do_reset();
    req_i[1] = 1'b1; lock_i[1] = 1'b1; addr_i[1] = 32'h4;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin req_i[0] = 1'b1; addr_i[0] = 32'h8; end
      eval_cycle();
      chk("burst_gnt1", 64'(gnt1), 64'(i >= 1 && i <= 8));
      chk("burst_gnt0", 64'(gnt0), 64'(i == 9));
      next_cycle();
    end

    // Asynchronous reset in the middle of a port-0 write grant.
    do_reset();
    req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 32'h20; wdata_i[0] = 32'hBEEF;
    eval_cycle();
    next_cycle();
    eval_cycle();
    chk("arst_pre_gnt0", 64'(gnt0), 64'(1));
    chk("arst_pre_we", 64'(mem_we), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_gnt0", 64'(gnt0), 64'(0));
    chk("arst_mem_we", 64'(mem_we), 64'(0));
    @(posedge clk);
    #1;
    chk("arst_no_commit", 64'(dmem[8]), 64'(0));
    reset = 1'b0;
    model_reset();
    eval_cycle();
    chk("arst_idle_gnt0", 64'(gnt0), 64'(0));
    next_cycle();
    eval_cycle();
    chk("arst_regrant", 64'(gnt0), 64'(1));
    next_cycle();
    chk("arst_late_commit", 64'(dmem[8]), 64'(32'hBEEF));

    // Randomized traffic; a requester holds its request unchanged until granted.
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          req_i[p]   = ($urandom_range(0, 9) < 7);
          we_i[p]    = 1'($urandom_range(0, 1));
          lock_i[p]  = ($urandom_range(0, 3) == 0);
          addr_i[p]  = AW'($urandom_range(0, 15)) << 2;
          wdata_i[p] = DW'($urandom);
        end
      end
      eval_cycle();
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
